// File: rtl/axis_rr_packet_arbiter_if.sv
// Handshake bundle between N_REQ upstream stream sources, the packet arbiter
// and the single shared downstream consumer.
interface axis_rr_packet_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ID   = $clog2(N_REQ)
);

  logic [N_REQ-1:0]         i_valid;
  logic [N_REQ*NB_DATA-1:0] i_data;
  logic [N_REQ-1:0]         i_last;
  logic [N_REQ-1:0]         o_ready;
  logic                     o_valid;
  logic [NB_DATA-1:0]       o_data;
  logic                     o_last;
  logic [NB_ID-1:0]         o_id;
  logic                     i_ready;

  // Arbiter side
  modport master (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_id
  );

  // Sources/sink side
  modport slave (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_id
  );

endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// N-to-1 AXI-Stream round-robin arbiter with packet-granular grant and a
// registered main+skid output stage; all upstream readies are registered.
module axis_rr_packet_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ID   = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  axis_rr_packet_arbiter_if.master bus,
  output logic                     o_busy,
  output logic [NB_ID-1:0]         o_grant
);

  localparam logic [NB_ID-1:0] PTR_RST = NB_ID'(N_REQ - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             state;
  logic [NB_ID-1:0]   ptr;
  logic [N_REQ-1:0]   ready_q;
  logic               main_v, main_last, skid_v, skid_last;
  logic [NB_DATA-1:0] main_data, skid_data;
  logic [NB_ID-1:0]   main_id, skid_id;

  logic               found;
  logic [NB_ID-1:0]   winner, idx;
  logic               xfer, drain, skid_nxt, beat_last;
  logic [NB_DATA-1:0] beat_data;

  // Round-robin search starting just after the last winner
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = NB_ID'((32'(ptr) + i) % N_REQ);
      if (!found && bus.i_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Granted beat and stage occupancy for the coming cycle
  always_comb begin
    beat_data = bus.i_data[32'(o_grant)*NB_DATA +: NB_DATA];
    beat_last = bus.i_last[o_grant];
    xfer      = (state == ST_LOCKED) && bus.i_valid[o_grant] && ready_q[o_grant];
    drain     = main_v && bus.i_ready;
    skid_nxt  = skid_v ? (main_v && !bus.i_ready)
                       : (xfer && main_v && !bus.i_ready);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ptr       <= PTR_RST;
      o_grant   <= '0;
      o_busy    <= 1'b0;
      ready_q   <= '0;
      main_v    <= 1'b0;
      main_data <= '0;
      main_last <= 1'b0;
      main_id   <= '0;
      skid_v    <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
      skid_id   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= '0;
          if (found) begin
            state   <= ST_LOCKED;
            o_grant <= winner;
            ptr     <= winner;
            o_busy  <= 1'b1;
            ready_q <= skid_nxt ? '0 : (N_REQ'(1) << winner);
          end
        end
        ST_LOCKED: begin
          if (xfer && beat_last) begin
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
            ready_q <= '0;
          end else begin
            ready_q <= skid_nxt ? '0 : (N_REQ'(1) << o_grant);
          end
        end
      endcase

      // Main refills from skid first, else from the incoming beat
      skid_v <= skid_nxt;
      if (drain || !main_v) begin
        if (skid_v) begin
          main_v    <= 1'b1;
          main_data <= skid_data;
          main_last <= skid_last;
          main_id   <= skid_id;
        end else if (xfer) begin
          main_v    <= 1'b1;
          main_data <= beat_data;
          main_last <= beat_last;
          main_id   <= o_grant;
        end else begin
          main_v    <= 1'b0;
        end
      end else if (xfer) begin
        skid_data <= beat_data;
        skid_last <= beat_last;
        skid_id   <= o_grant;
      end
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = main_v;
  assign bus.o_data  = main_data;
  assign bus.o_last  = main_last;
  assign bus.o_id    = main_id;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench: a vector table for the two-packet case plus source/sink
// sequences for round-robin order, backpressure, mid-packet reset and stalls.
module tb_axis_rr_packet_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       o_busy;
  logic [1:0] o_grant;

  axis_rr_packet_arbiter_if #(.N_REQ(N), .NB_DATA(W)) bus ();

  axis_rr_packet_arbiter #(.N_REQ(N), .NB_DATA(W)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus    (bus),
    .o_busy (o_busy),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] d0;
    logic [31:0] d2;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    logic [1:0]  e_id;
    logic        e_busy;
    logic [1:0]  e_grant;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  id;
  } beat_t;

  int total = 0;
  int bad   = 0;

  vec_t  tbl[$];
  beat_t outq[$];

  bit          gate    [N];
  int          sent    [N];
  int          n_beats [N];
  int          pkt_len [N];
  logic [31:0] base    [N];
  int          occ;
  bit          rdy;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [1:0]  prev_id;
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d0, logic [31:0] d2,
                              logic [3:0] er, logic ev, logic [31:0] ed, logic el,
                              logic [1:0] eid, logic eb, logic [1:0] eg);
    vec_t r;
    r.valid = v;   r.last = l;    r.d0 = d0;     r.d2 = d2;
    r.e_ready = er; r.e_valid = ev; r.e_data = ed; r.e_last = el;
    r.e_id = eid;  r.e_busy = eb; r.e_grant = eg;
    return r;
  endfunction

  task automatic reset_dut();
    i_rst = 1'b1;
    bus.i_valid = '0;
    bus.i_data  = '0;
    bus.i_last  = '0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_ready", 32'(bus.o_ready), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_id",    32'(bus.o_id), 0);
    chk("rst_data",  bus.o_data, 0);
    chk("rst_last",  32'(bus.o_last), 0);
    i_rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      gate[k] = 1'b0; sent[k] = 0; n_beats[k] = 0; pkt_len[k] = 1; base[k] = '0;
    end
    occ = 0;
    rdy = 1'b1;
    prev_stall = 1'b0;
    outq.delete();
  endtask

  // One clock of source models, sink capture and output-stage invariants
  task automatic cyc();
    logic [3:0]   v, l, hs;
    logic [127:0] d;
    beat_t        b;
    bit           out_hs;
    for (int k = 0; k < N; k++) begin
      v[k] = gate[k] && (sent[k] < n_beats[k]);
      d[k*32 +: 32] = base[k] + 32'(sent[k]);
      l[k] = (sent[k] % pkt_len[k]) == (pkt_len[k] - 1);
    end
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
    bus.i_ready = rdy;
    chk("ready_onehot", 32'($countones(bus.o_ready) <= 1), 1);
    chk("valid_vs_occ", 32'(bus.o_valid), 32'(occ > 0));
    if (occ == 2) chk("ready_when_full", 32'(bus.o_ready), 0);
    if (prev_stall) begin
      chk("stall_data", bus.o_data, prev_data);
      chk("stall_last", 32'(bus.o_last), 32'(prev_last));
      chk("stall_id",   32'(bus.o_id), 32'(prev_id));
    end
    out_hs = bus.o_valid && rdy;
    if (out_hs) begin
      b.d = bus.o_data; b.l = bus.o_last; b.id = bus.o_id;
      outq.push_back(b);
    end
    hs = v & bus.o_ready;
    prev_stall = bus.o_valid && !rdy;
    prev_data  = bus.o_data;
    prev_last  = bus.o_last;
    prev_id    = bus.o_id;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) sent[k]++;
    occ = occ + ((hs != 0) ? 1 : 0) - (out_hs ? 1 : 0);
  endtask

  task automatic check_beat(input int i, input logic [31:0] d, input logic l, input logic [1:0] id);
    if (i < outq.size()) begin
      chk($sformatf("beat%0d_data", i), outq[i].d, d);
      chk($sformatf("beat%0d_last", i), 32'(outq[i].l), 32'(l));
      chk($sformatf("beat%0d_id", i),   32'(outq[i].id), 32'(id));
    end else begin
      chk($sformatf("beat%0d_missing", i), 32'(outq.size()), 32'(i + 1));
    end
  endtask

  initial begin
    // Ten idle cycles, then requesters 0 and 2 with 3-beat packets
    for (int i = 0; i < 10; i++) tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0101, 4'b0000, 32'hA0, 32'hC0, 4'b0000, 0, 0,      0, 0, 0, 0));
    tbl.push_back(mk(4'b0101, 4'b0000, 32'hA0, 32'hC0, 4'b0001, 0, 0,      0, 0, 1, 0));
    tbl.push_back(mk(4'b0101, 4'b0000, 32'hA1, 32'hC0, 4'b0001, 1, 32'hA0, 0, 0, 1, 0));
    tbl.push_back(mk(4'b0101, 4'b0001, 32'hA2, 32'hC0, 4'b0001, 1, 32'hA1, 0, 0, 1, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 0,      32'hC0, 4'b0000, 1, 32'hA2, 1, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 0,      32'hC0, 4'b0100, 0, 0,      0, 0, 1, 2));
    tbl.push_back(mk(4'b0100, 4'b0000, 0,      32'hC1, 4'b0100, 1, 32'hC0, 0, 2, 1, 2));
    tbl.push_back(mk(4'b0100, 4'b0100, 0,      32'hC2, 4'b0100, 1, 32'hC1, 0, 2, 1, 2));
    tbl.push_back(mk(4'b0000, 4'b0000, 0,      0,      4'b0000, 1, 32'hC2, 1, 2, 0, 2));
    tbl.push_back(mk(4'b0000, 4'b0000, 0,      0,      4'b0000, 0, 0,      0, 0, 0, 2));

    reset_dut();
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("tbl%0d_ready", i), 32'(bus.o_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_busy", i),  32'(o_busy),      32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_grant", i), 32'(o_grant),     32'(tbl[i].e_grant));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_data", i), bus.o_data,       tbl[i].e_data);
        chk($sformatf("tbl%0d_last", i), 32'(bus.o_last), 32'(tbl[i].e_last));
        chk($sformatf("tbl%0d_id", i),   32'(bus.o_id),   32'(tbl[i].e_id));
      end
      bus.i_valid = tbl[i].valid;
      bus.i_last  = tbl[i].last;
      bus.i_data  = {32'h0, tbl[i].d2, 32'h0, tbl[i].d0};
      bus.i_ready = 1'b1;
      @(posedge i_clk);
      #1;
    end

    // All four requesters with 1-beat packets: order 0,1,2,3,0,1,2,3
    reset_dut();
    for (int k = 0; k < N; k++) begin
      gate[k] = 1'b1; n_beats[k] = 2; pkt_len[k] = 1; base[k] = 32'(k * 16);
    end
    for (int c = 0; c < 60 && outq.size() < 8; c++) cyc();
    for (int i = 0; i < 8; i++) check_beat(i, 32'((i % 4) * 16 + i / 4), 1'b1, 2'(i % 4));

    // Requester 1, 8 beats, downstream ready pattern 1,0,0,1
    reset_dut();
    gate[1] = 1'b1; n_beats[1] = 8; pkt_len[1] = 8; base[1] = 32'h100;
    for (int c = 0; c < 80 && outq.size() < 8; c++) begin
      rdy = pat[c % 4];
      cyc();
    end
    rdy = 1'b1;
    repeat (4) cyc();
    chk("bp_count", 32'(outq.size()), 8);
    for (int i = 0; i < 8; i++) check_beat(i, 32'h100 + 32'(i), i == 7, 2'd1);

    // Requester 3 mid-packet, then a one-cycle reset
    reset_dut();
    gate[3] = 1'b1; n_beats[3] = 4; pkt_len[3] = 4; base[3] = 32'h300;
    for (int c = 0; c < 20 && sent[3] < 2; c++) cyc();
    chk("pre_rst_sent", 32'(sent[3]), 2);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("midrst_valid", 32'(bus.o_valid), 0);
    chk("midrst_busy",  32'(o_busy), 0);
    chk("midrst_ready", 32'(bus.o_ready), 0);
    sent[3] = 0; occ = 0; prev_stall = 1'b0; outq.delete();
    gate[0] = 1'b1; n_beats[0] = 1; pkt_len[0] = 1; base[0] = 32'hE0;
    cyc();
    chk("post_rst_grant", 32'(o_grant), 0);
    chk("post_rst_busy",  32'(o_busy), 1);
    chk("post_rst_ready", 32'(bus.o_ready), 32'h1);
    for (int c = 0; c < 40 && outq.size() < 5; c++) cyc();
    check_beat(0, 32'hE0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) check_beat(i + 1, 32'h300 + 32'(i), i == 3, 2'd3);

    // Requester 2 pauses mid-packet while requester 0 waits
    reset_dut();
    gate[2] = 1'b1; n_beats[2] = 4; pkt_len[2] = 4; base[2] = 32'h200;
    n_beats[0] = 1; pkt_len[0] = 1; base[0] = 32'hE0;
    for (int c = 0; c < 20 && sent[2] < 2; c++) cyc();
    gate[2] = 1'b0;
    gate[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk($sformatf("pause%0d_grant", c), 32'(o_grant), 2);
      chk($sformatf("pause%0d_rdy0", c),  32'(bus.o_ready[0]), 0);
      chk($sformatf("pause%0d_busy", c),  32'(o_busy), 1);
    end
    gate[2] = 1'b1;
    for (int c = 0; c < 40 && outq.size() < 5; c++) cyc();
    for (int i = 0; i < 4; i++) check_beat(i, 32'h200 + 32'(i), i == 3, 2'd2);
    check_beat(4, 32'hE0, 1'b1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- N-to-1 AXI-Stream arbiter. Shares one downstream stream channel between N_REQ requesters at packet granularity.
- Round-robin grant, held for the whole packet, until the beat with last=1 is accepted.
- Output is a registered two-entry (main + skid) stage. All upstream ready signals are registered, so there is no combinational path from i_ready to any o_ready.
- Sits in front of shared stream consumers (DMA writer, serializer) inside the latency-insensitive fabric.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- NB_DATA, 32, data width per requester.
- NB_ID, $clog2(N_REQ), width of the source-index sideband.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  N_REQ  per-requester valid.
- i_data  input  N_REQ*NB_DATA  per-requester data; requester k occupies bits [k*NB_DATA +: NB_DATA].
- i_last  input  N_REQ  per-requester end-of-packet.
- o_ready  output  N_REQ  per-requester ready, registered, one-hot or zero.
- o_valid  output  1  downstream valid.
- o_data  output  NB_DATA  downstream data.
- o_last  output  1  downstream end-of-packet.
- o_id  output  NB_ID  index of the requester that produced the current output beat.
- i_ready  input  1  downstream ready.
- o_busy  output  1  high while in LOCKED state.
- o_grant  output  NB_ID  currently or most recently granted requester.

Behaviour:
- Single clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values:
  - o_ready=0, o_valid=0, o_last=0, o_busy=0, o_grant=0, o_id=0, o_data=0.
  - Skid entry empty; state IDLE; rr pointer = N_REQ-1, so requester 0 has first priority.
- State machine, two states:
  - IDLE: if any i_valid, pick the first set index searching from (ptr+1) mod N_REQ upward with wrap. Next cycle: state=LOCKED, o_grant=winner, ptr=winner.
  - IDLE with no i_valid: stay IDLE.
  - LOCKED: o_ready[o_grant] mirrors the stage's internal ready; all other o_ready bits are 0. A beat transfers when i_valid[g] & o_ready[g].
  - LOCKED exit: when the transferred beat has i_last[g]=1, o_ready drops to 0 next cycle and state returns to IDLE.
  - One arbitration bubble cycle per packet is required and accepted.
- Non-granted requesters are never acked. Their valid/data may change freely; no AXIS rule is enforced on them.
- Output stage (skid behaviour):
  - Internal ready = skid entry empty, registered.
  - Accepted beat goes to main if main is empty or being drained that cycle; otherwise to skid.
  - When main drains and skid is full, skid moves to main.
  - Ready deasserts the cycle after the skid fills while the output is stalled. It reasserts the cycle after the skid empties.
  - Latency: accepted beat appears on o_data/o_last/o_id on the next cycle when the stage is empty.
  - Throughput: 1 beat/clk within a packet while i_ready=1.
- o_data/o_last/o_id hold stable while o_valid & ~i_ready. o_valid drops only after a transfer with nothing else queued.
- Packets are never interleaved on the output. o_id is constant between two o_last beats.
- Single-beat packet (i_last on first beat): legal, grant released after that one beat.
- Requester dropping i_valid mid-packet: grant held, no timeout.
- A requester asserting i_valid the same cycle the grant returns to IDLE is considered in that IDLE cycle.
- Reset mid-packet:
  - All buffered beats are discarded; o_valid=0 the cycle after i_rst.
  - Pointer resets; the partial packet is not completed.
- o_busy=1 exactly in LOCKED.

Test Plan:
- Reset, then all i_valid=0 for 10 cycles -> o_valid=0, o_ready=0, o_busy=0 throughout.
- Requesters 0 and 2 each send 3-beat packets (data 0xA0..A2, 0xC0..C2), i_ready=1 -> output A0,A1,A2 (o_id=0, o_last on A2), then C0,C1,C2 (o_id=2). No interleave; one idle cycle between packets.
- All 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0,1. Each o_id appears exactly once per 4 packets.
- Requester 1 sends 8 beats; i_ready toggles 1,0,0,1,… -> all 8 beats out in order, none dropped or duplicated. o_ready[1]=0 within one cycle of the skid filling; o_data stable whenever o_valid & ~i_ready.
- Requester 3 packet in flight, 2 beats accepted, i_rst pulsed for 1 cycle -> next cycle o_valid=0, o_busy=0. Requester 0 is granted first afterwards.
- Requester 2 mid-packet deasserts i_valid for 5 cycles while requester 0 is valid -> o_grant stays 2, o_ready[0]=0. Requester 0 is served only after requester 2's last beat.
